// File: rtl/div32by16_pkg.sv
// rtl/div32by16_pkg.sv - shared state encoding and write-strobe indices for the divider
package div32by16_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    localparam int WE_LO = 0;
    localparam int WE_HI = 1;
    localparam int WE_DV = 2;

endpackage

// File: rtl/div32by16_step.sv
// rtl/div32by16_step.sv - one combinational restoring-division step
module div32by16_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] dv,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] r_sh;

    // Shift {r,q} left by one; subtract the divisor from the WIDTH+1 bit partial remainder when it fits.
    // The difference is always below dv, so it is exact in WIDTH bits.
    always_comb begin
        r_sh = {r_in, q_in[WIDTH-1]};
        if (r_sh >= {1'b0, dv}) begin
            r_out = r_sh[WIDTH-1:0] - dv;
            q_out = {q_in[WIDTH-2:0], 1'b1};
        end else begin
            r_out = r_sh[WIDTH-1:0];
            q_out = {q_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div32by16.sv
// rtl/div32by16.sv - memory-mapped unsigned 2W/W bit-serial restoring divider
module div32by16
    import div32by16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               resetq,
    input  logic [2:0]         we,
    input  logic [WIDTH-1:0]   din,
    output logic [2*WIDTH-1:0] dout,
    output logic               ready,
    output logic               dz,
    output logic               ov
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] lo, hi, dv;
    logic [2:0]       loaded;
    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r, q, d;
    logic [WIDTH-1:0] r_nxt, q_nxt;
    logic             dz_p, ov_p;
    logic             start;

    assign start = (state == IDLE) && (&loaded);

    div32by16_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (r),
        .q_in  (q),
        .dv    (d),
        .r_out (r_nxt),
        .q_out (q_nxt)
    );

    // Operand registers; a write on the start edge re-arms its loaded bit for the next op.
    always_ff @(posedge clk) begin
        if (resetq) begin
            lo     <= '0;
            hi     <= '0;
            dv     <= '0;
            loaded <= 3'b000;
        end else begin
            if (we[WE_LO]) lo <= din;
            if (we[WE_HI]) hi <= din;
            if (we[WE_DV]) dv <= din;
            loaded <= (start ? 3'b000 : loaded) | we;
        end
    end

    // Control FSM: snapshot operands, screen dz/ov, iterate WIDTH steps, publish result.
    always_ff @(posedge clk) begin
        if (resetq) begin
            state <= IDLE;
            dout  <= '0;
            ready <= 1'b1;
            dz    <= 1'b0;
            ov    <= 1'b0;
            dz_p  <= 1'b0;
            ov_p  <= 1'b0;
            cnt   <= '0;
            r     <= '0;
            q     <= '0;
            d     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r     <= hi;
                        q     <= lo;
                        d     <= dv;
                        ready <= 1'b0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    dz_p <= 1'b0;
                    ov_p <= 1'b0;
                    if (d == '0) begin
                        dz_p  <= 1'b1;
                        q     <= '1;
                        r     <= q;
                        state <= DONE;
                    end else if (r >= d) begin
                        // High word at or above the divisor means the quotient cannot fit.
                        ov_p  <= 1'b1;
                        q     <= '1;
                        r     <= '0;
                        state <= DONE;
                    end else begin
                        cnt   <= CW'(WIDTH - 1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    r   <= r_nxt;
                    q   <= q_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= DONE;
                end
                DONE: begin
                    dout  <= {r, q};
                    dz    <= dz_p;
                    ov    <= ov_p;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div32by16.sv
// tb/tb_div32by16.sv - randomized self-checking bench for div32by16 against an arithmetic model
module tb_div32by16;

    logic        clk;
    logic        resetq;
    logic [2:0]  we;
    logic [15:0] din;
    logic [31:0] dout;
    logic        ready, dz, ov;

    int vectors;
    int miscompares;
    bit chk_en;

    // Model state: operand shadows, loaded bits, and a latency countdown for the op in flight.
    logic [15:0] m_lo, m_hi, m_dv;
    logic [2:0]  m_loaded;
    bit          m_busy;
    int          m_left;
    logic [33:0] m_pend;
    logic [31:0] exp_dout;
    logic        exp_ready, exp_dz, exp_ov;

    div32by16 #(.WIDTH(16)) dut (
        .clk    (clk),
        .resetq (resetq),
        .we     (we),
        .din    (din),
        .dout   (dout),
        .ready  (ready),
        .dz     (dz),
        .ov     (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {dz, ov, remainder, quotient} from plain integer division.
    function automatic logic [33:0] ref_div(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] dv);
        logic [31:0] n;
        logic [31:0] qq;
        logic [31:0] rr;
        n = {hi, lo};
        if (dv == 16'd0) return {2'b10, lo, 16'hFFFF};
        qq = n / {16'd0, dv};
        rr = n % {16'd0, dv};
        if (qq > 32'h0000_FFFF) return {2'b01, 16'h0000, 16'hFFFF};
        return {2'b00, rr[15:0], qq[15:0]};
    endfunction

    always @(posedge clk) begin : model
        bit st;
        if (resetq) begin
            m_loaded  = 3'b000;
            m_busy    = 0;
            m_left    = 0;
            exp_dout  = 32'd0;
            exp_ready = 1'b1;
            exp_dz    = 1'b0;
            exp_ov    = 1'b0;
        end else begin
            st = !m_busy && (m_loaded == 3'b111);
            if (st) begin
                m_pend    = ref_div(m_lo, m_hi, m_dv);
                m_busy    = 1;
                exp_ready = 1'b0;
                m_left    = (m_pend[33] || m_pend[32]) ? 2 : 18;
            end else if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    exp_dout  = m_pend[31:0];
                    exp_dz    = m_pend[33];
                    exp_ov    = m_pend[32];
                    exp_ready = 1'b1;
                    m_busy    = 0;
                end
            end
            if (we[0]) m_lo = din;
            if (we[1]) m_hi = din;
            if (we[2]) m_dv = din;
            m_loaded = (st ? 3'b000 : m_loaded) | we;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (dout !== exp_dout || ready !== exp_ready || dz !== exp_dz || ov !== exp_ov) begin
                miscompares++;
                $display("FAIL cycle@%0t: dout=%h ready=%b dz=%b ov=%b, expected dout=%h ready=%b dz=%b ov=%b",
                         $time, dout, ready, dz, ov, exp_dout, exp_ready, exp_dz, exp_ov);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic wr(input logic [2:0] w, input logic [15:0] d);
        @(negedge clk);
        we  = w;
        din = d;
        @(posedge clk);
        #1;
        we  = 3'b000;
    endtask

    task automatic load3(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] dv);
        wr(3'b001, lo);
        wr(3'b010, hi);
        wr(3'b100, dv);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 200);
        chk("ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    int ord [6][3] = '{'{0,1,2}, '{0,2,1}, '{1,0,2}, '{1,2,0}, '{2,0,1}, '{2,1,0}};

    initial begin
        int n;
        logic [15:0] lo, hi, dv;
        logic [15:0] vals [3];
        int p;
        vectors     = 0;
        miscompares = 0;
        chk_en      = 0;
        resetq      = 1'b1;
        we          = 3'b000;
        din         = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        resetq = 1'b0;
        chk_en = 1;

        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_dout", dout, 32'd0);

        // 1: 100000 / 7
        load3(16'h86A0, 16'h0001, 16'd7);
        wait_ready(n);
        chk("t1_latency", n, 32'd19);
        chk("t1_dout", dout, 32'h0005_37CD);
        chk("t1_model", exp_dout, 32'h0005_37CD);
        chk("t1_flags", {30'd0, dz, ov}, 32'd0);

        // 2: max legal quotient
        load3(16'h0001, 16'hFFFE, 16'hFFFF);
        wait_ready(n);
        chk("t2_dout", dout, 32'h0000_FFFF);
        chk("t2_ov", {31'd0, ov}, 32'd0);

        // 3: divide by zero
        wr(3'b100, 16'd0);
        wr(3'b001, 16'h1234);
        wr(3'b010, 16'h0000);
        wait_ready(n);
        chk("t3_latency", n, 32'd3);
        chk("t3_dout", dout, 32'h1234_FFFF);
        chk("t3_dz", {31'd0, dz}, 32'd1);

        // 4: overflow, then a legal op clears the flags
        load3(16'h0000, 16'h0007, 16'd7);
        wait_ready(n);
        chk("t4_dout", dout, 32'h0000_FFFF);
        chk("t4_ov", {31'd0, ov}, 32'd1);
        load3(16'd100, 16'd0, 16'd3);
        wait_ready(n);
        chk("t4b_dout", dout, 32'h0001_0021);
        chk("t4b_flags", {30'd0, dz, ov}, 32'd0);

        // 5: partial load does not start; rewrite during RUN is queued
        wr(3'b100, 16'd3);
        wr(3'b001, 16'd100);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_nostart", {31'd0, ready}, 32'd1);
        wr(3'b010, 16'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("t5_busy", {31'd0, ready}, 32'd0);
        wr(3'b011, 16'd0);
        wr(3'b001, 16'd1000);
        wr(3'b100, 16'd7);
        wait_ready(n);
        chk("t5_first", dout, 32'h0001_0021);
        wait_ready(n);
        chk("t5_second_lat", n, 32'd19);
        chk("t5_second", dout, 32'h0006_008E);

        // 6: reset mid-RUN aborts, then a fresh op works
        load3(16'hFFFF, 16'h0123, 16'h4567);
        repeat (10) @(posedge clk);
        @(negedge clk);
        resetq = 1'b1;
        @(posedge clk);
        #1;
        resetq = 1'b0;
        chk("t6_ready", {31'd0, ready}, 32'd1);
        chk("t6_dout", dout, 32'd0);
        repeat (25) @(posedge clk);
        #1;
        chk("t6_nostart", {31'd0, ready}, 32'd1);
        load3(16'h86A0, 16'h0001, 16'd7);
        wait_ready(n);
        chk("t6_after", dout, 32'h0005_37CD);

        // Randomized operations, random write order and gaps.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0: begin dv = 16'd0; hi = 16'($urandom); lo = 16'($urandom); end
                1: begin dv = 16'($urandom_range(1, 65535)); hi = 16'($urandom_range(32'(dv), 65535)); lo = 16'($urandom); end
                default: begin dv = 16'($urandom_range(1, 65535)); hi = 16'($urandom_range(0, 32'(dv) - 1)); lo = 16'($urandom); end
            endcase
            if ($urandom_range(0, 7) == 0) begin
                lo = hi;
                wr(3'b011, hi);
                wr(3'b100, dv);
            end else begin
                vals[0] = lo;
                vals[1] = hi;
                vals[2] = dv;
                p = $urandom_range(0, 5);
                for (int k = 0; k < 3; k++) begin
                    wr(3'b001 << ord[p][k], vals[ord[p][k]]);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
            wait_ready(n);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        @(negedge clk);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
